// File: rtl/alu_vector_sequencer_pkg.sv
// Shared definitions for the vector ALU sequencer: alufn codes, ALU width and FSM encoding.
// Imported by the sequencer, its opcode legality checker and the instruction decoder.
package alu_vector_sequencer_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALUFN_W    = 6;

    localparam logic [ALUFN_W-1:0] ALUFN_ADD = 6'b000000;
    localparam logic [ALUFN_W-1:0] ALUFN_SUB = 6'b000001;
    localparam logic [ALUFN_W-1:0] ALUFN_MUL = 6'b000010;
    localparam logic [ALUFN_W-1:0] ALUFN_AND = 6'b000100;
    localparam logic [ALUFN_W-1:0] ALUFN_OR  = 6'b000101;
    localparam logic [ALUFN_W-1:0] ALUFN_XOR = 6'b000110;
    localparam logic [ALUFN_W-1:0] ALUFN_SHL = 6'b001000;
    localparam logic [ALUFN_W-1:0] ALUFN_SHR = 6'b001001;
    localparam logic [ALUFN_W-1:0] ALUFN_SLT = 6'b001010;
    localparam logic [ALUFN_W-1:0] ALUFN_SEQ = 6'b001011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REJ   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_vector_sequencer_op_legal.sv
// Combinational alufn legality check; the decoder instantiates the same block so both agree.
module alu_vector_sequencer_op_legal
    import alu_vector_sequencer_pkg::*;
(
    input  logic [ALUFN_W-1:0] op,
    output logic               legal
);

    always_comb begin
        legal = 1'b0;
        case (op)
            ALUFN_ADD, ALUFN_SUB, ALUFN_MUL,
            ALUFN_AND, ALUFN_OR,  ALUFN_XOR,
            ALUFN_SHL, ALUFN_SHR, ALUFN_SLT, ALUFN_SEQ: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_vector_sequencer.sv
// Steps the 8-bit ALU over the elements of one vector instruction: read -> ALU -> writeback,
// one element per cycle, with zero/overflow reduced into vector flags.
module alu_vector_sequencer
    import alu_vector_sequencer_pkg::*;
#(
    parameter int DATA_W   = ALU_DATA_W,
    parameter int VLEN_MAX = 8,
    parameter int EL_W     = 3,
    parameter int VR_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [ALUFN_W-1:0]   instr_op,
    input  logic [VR_W-1:0]      instr_vd,
    input  logic [VR_W-1:0]      instr_va,
    input  logic [VR_W-1:0]      instr_vb,
    input  logic [EL_W:0]        instr_vlen,
    output logic [VR_W+EL_W-1:0] rf_raddr_a,
    output logic [VR_W+EL_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]    rf_rdata_a,
    input  logic [DATA_W-1:0]    rf_rdata_b,
    output logic                 rf_we,
    output logic [VR_W+EL_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [ALUFN_W-1:0]   alu_fn,
    output logic                 alu_enable,
    input  logic [DATA_W-1:0]    alu_otp,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    output logic                 done,
    output logic                 err,
    output logic                 vflag_zero,
    output logic                 vflag_ovf
);

    localparam logic [EL_W:0] VLEN_LIM = VLEN_MAX[EL_W:0];
    localparam logic [EL_W:0] VLEN_ONE = 1;

    seq_state_t         state;
    logic [ALUFN_W-1:0] op_q;
    logic [VR_W-1:0]    vd_q;
    logic [VR_W-1:0]    va_q;
    logic [VR_W-1:0]    vb_q;
    logic [EL_W:0]      vlen_q;
    logic [EL_W:0]      vlen_m1_q;
    logic [EL_W:0]      iss_cnt;

    logic               vld_p0;
    logic [EL_W-1:0]    elem_p0;
    logic               vld_p1;
    logic               last_p1;
    logic [EL_W-1:0]    elem_p1;
    logic [ALUFN_W-1:0] fn_p1;
    logic               vld_p2;
    logic               last_p2;

    logic op_ok;
    logic vlen_ok;
    logic accept;

    alu_vector_sequencer_op_legal u_op_legal (
        .op    (instr_op),
        .legal (op_ok)
    );

    assign vlen_ok    = (instr_vlen != '0) && (instr_vlen <= VLEN_LIM);
    assign accept     = instr_valid && instr_ready;

    assign alu_a      = rf_rdata_a;
    assign alu_b      = rf_rdata_b;
    assign alu_fn     = fn_p1;
    assign alu_enable = vld_p1;
    assign rf_we      = vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            vflag_zero  <= 1'b0;
            vflag_ovf   <= 1'b0;
            op_q        <= '0;
            vd_q        <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            vlen_q      <= '0;
            vlen_m1_q   <= '0;
            iss_cnt     <= '0;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            vld_p0      <= 1'b0;
            elem_p0     <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            elem_p1     <= '0;
            fn_p1       <= '0;
            vld_p2      <= 1'b0;
            last_p2     <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
        end else begin
            // stage 0: control FSM and read-address issue
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= instr_op;
                        vd_q        <= instr_vd;
                        va_q        <= instr_va;
                        vb_q        <= instr_vb;
                        vlen_q      <= instr_vlen;
                        vlen_m1_q   <= instr_vlen - VLEN_ONE;
                        instr_ready <= 1'b0;
                        if (op_ok && vlen_ok) begin
                            state      <= ST_RUN;
                            rf_raddr_a <= {instr_va, {EL_W{1'b0}}};
                            rf_raddr_b <= {instr_vb, {EL_W{1'b0}}};
                            vld_p0     <= 1'b1;
                            elem_p0    <= '0;
                            iss_cnt    <= VLEN_ONE;
                            vflag_zero <= 1'b1;
                            vflag_ovf  <= 1'b0;
                        end else begin
                            state      <= ST_REJ;
                            done       <= 1'b1;
                            err        <= 1'b1;
                            vflag_zero <= 1'b0;
                            vflag_ovf  <= 1'b0;
                        end
                    end
                end
                ST_REJ: begin
                    done        <= 1'b0;
                    err         <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_RUN: begin
                    if (iss_cnt < vlen_q) begin
                        rf_raddr_a <= {va_q, iss_cnt[EL_W-1:0]};
                        rf_raddr_b <= {vb_q, iss_cnt[EL_W-1:0]};
                        elem_p0    <= iss_cnt[EL_W-1:0];
                        iss_cnt    <= iss_cnt + VLEN_ONE;
                    end else begin
                        vld_p0 <= 1'b0;
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (vld_p2 && last_p2) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    done        <= 1'b0;
                    err         <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase

            // stage 1: read data arrives, element presented to the ALU
            vld_p1  <= vld_p0;
            elem_p1 <= elem_p0;
            last_p1 <= vld_p0 && ({1'b0, elem_p0} == vlen_m1_q);
            fn_p1   <= vld_p0 ? op_q : '0;

            // stage 2: capture ALU result for writeback and fold the flags
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            if (vld_p1) begin
                rf_waddr   <= {vd_q, elem_p1};
                rf_wdata   <= alu_otp;
                vflag_zero <= vflag_zero & alu_zero;
                vflag_ovf  <= vflag_ovf | alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Scoreboard bench: issued instructions push expected writes and retirements; a negedge monitor pops and compares.
module tb_alu_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  instr_op;
    logic [2:0]  instr_vd;
    logic [2:0]  instr_va;
    logic [2:0]  instr_vb;
    logic [3:0]  instr_vlen;
    logic [5:0]  rf_raddr_a;
    logic [5:0]  rf_raddr_b;
    logic [7:0]  rf_rdata_a;
    logic [7:0]  rf_rdata_b;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [5:0]  alu_fn;
    logic        alu_enable;
    logic [7:0]  alu_otp;
    logic        alu_zero;
    logic        alu_ovf;
    logic        done;
    logic        err;
    logic        vflag_zero;
    logic        vflag_ovf;

    typedef struct { logic [5:0] addr; logic [7:0] data; int due; } wexp_t;
    typedef struct { logic e; logic z; logic o; int due; } dexp_t;

    wexp_t wq[$];
    dexp_t dq[$];

    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    logic mon_en = 1'b0;
    logic [5:0] cur_op = 6'd0;

    logic [7:0] mem [64];
    logic       pre_we;
    logic [5:0] pre_addr;
    logic [7:0] pre_data;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    alu_vector_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_vd(instr_vd), .instr_va(instr_va), .instr_vb(instr_vb),
        .instr_vlen(instr_vlen),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_enable(alu_enable),
        .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .done(done), .err(err), .vflag_zero(vflag_zero), .vflag_ovf(vflag_ovf)
    );

    // register file: synchronous read, one write port shared with the preload path
    always @(posedge clk) begin
        rf_rdata_a <= mem[rf_raddr_a];
        rf_rdata_b <= mem[rf_raddr_b];
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // combinational ALU for the ops the vectors use
    always_comb begin
        logic [7:0] r;
        r       = 8'd0;
        alu_ovf = 1'b0;
        case (alu_fn)
            6'b000000: begin
                r       = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]);
            end
            6'b000001: begin
                r       = alu_a - alu_b;
                alu_ovf = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]);
            end
            6'b000100: r = alu_a & alu_b;
            6'b000110: r = alu_a ^ alu_b;
            default:   r = 8'd0;
        endcase
        alu_otp  = r;
        alu_zero = (r == 8'd0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rf_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write", rf_waddr, rf_wdata);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    chk("wr_addr", int'(rf_waddr), int'(w.addr));
                    chk("wr_data", int'(rf_wdata), int'(w.data));
                    chk("wr_cycle", ecnt, w.due);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: err %0d, expected no done", err);
                end else begin
                    dexp_t d;
                    d = dq.pop_front();
                    chk("done_err", int'(err), int'(d.e));
                    chk("vflag_zero", int'(vflag_zero), int'(d.z));
                    chk("vflag_ovf", int'(vflag_ovf), int'(d.o));
                    chk("done_cycle", ecnt, d.due);
                end
            end
            if (err && !done) chk("err_without_done", int'(done), 1);
            if (alu_enable) chk("alu_fn", int'(alu_fn), int'(cur_op));
            else            chk("alu_fn_idle", int'(alu_fn), 0);
        end
    end

    task automatic preload(input logic [2:0] vr, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = {vr, 3'(i)};
            pre_data = v[8*i +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [2:0] vd, input logic [2:0] va,
                         input logic [2:0] vb, input logic [3:0] vlen, input logic [63:0] res,
                         input int nwr, input bit exp_done, input bit exp_err,
                         input bit ez, input bit eo, input int hold, output int a);
        int n;
        int rdy_due;
        dexp_t d;
        wexp_t w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 100);
        chk("ready_before_issue", int'(instr_ready), 1);
        cur_op      = op;
        instr_op    = op;
        instr_vd    = vd;
        instr_va    = va;
        instr_vb    = vb;
        instr_vlen  = vlen;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        a = ecnt;
        for (int i = 0; i < nwr; i++) begin
            w.addr = {vd, 3'(i)};
            w.data = res[8*i +: 8];
            w.due  = a + 2 + i;
            wq.push_back(w);
        end
        if (exp_done) begin
            d.e   = exp_err;
            d.z   = ez;
            d.o   = eo;
            d.due = exp_err ? a : a + int'(vlen) + 2;
            dq.push_back(d);
        end
        if (hold > 0) begin
            instr_op   = 6'b000000;
            instr_vd   = 3'd0;
            instr_vlen = 4'd1;
            repeat (hold) @(negedge clk);
        end
        instr_valid = 1'b0;
        if (exp_done) begin
            rdy_due = exp_err ? a + 1 : a + int'(vlen) + 3;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!instr_ready && n < 100);
            chk("ready_cycle", ecnt, rdy_due);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 6'd0;
        instr_vd    = 3'd0;
        instr_va    = 3'd0;
        instr_vb    = 3'd0;
        instr_vlen  = 4'd0;
        pre_we      = 1'b0;
        pre_addr    = 6'd0;
        pre_data    = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_we", int'(rf_we), 0);
        chk("rst_alu_en", int'(alu_enable), 0);
        chk("rst_alu_fn", int'(alu_fn), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_vzero", int'(vflag_zero), 0);
        chk("rst_vovf", int'(vflag_ovf), 0);
        chk("rst_raddr_a", int'(rf_raddr_a), 0);
        chk("rst_waddr", int'(rf_waddr), 0);
        chk("rst_wdata", int'(rf_wdata), 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        preload(3'd1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1});
        preload(3'd2, {8'd0, 8'd0, 8'd0, 8'd0, 8'd40, 8'd30, 8'd20, 8'd10});
        preload(3'd4, {48'd0, 8'd7, 8'd5});
        preload(3'd5, {48'd0, 8'd7, 8'd5});
        preload(3'd0, {48'd0, 8'h80, 8'd100});
        preload(3'd7, {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11});

        // ADD, 4 elements
        issue(6'b000000, 3'd3, 3'd1, 3'd2, 4'd4, {32'd0, 8'd44, 8'd33, 8'd22, 8'd11},
              4, 1, 0, 0, 0, 0, a);
        // SUB to all zeros
        issue(6'b000001, 3'd6, 3'd4, 3'd5, 4'd2, 64'd0, 2, 1, 0, 1, 0, 0, a);
        // signed overflow on both elements, second result zero
        issue(6'b000000, 3'd5, 3'd0, 3'd0, 4'd2, {48'd0, 8'h00, 8'hC8}, 2, 1, 0, 0, 1, 0, a);
        // illegal ops and illegal lengths
        issue(6'b000011, 3'd3, 3'd1, 3'd2, 4'd3, 64'd0, 0, 1, 1, 0, 0, 0, a);
        issue(6'b001100, 3'd3, 3'd1, 3'd2, 4'd1, 64'd0, 0, 1, 1, 0, 0, 0, a);
        issue(6'b000000, 3'd3, 3'd1, 3'd2, 4'd0, 64'd0, 0, 1, 1, 0, 0, 0, a);
        issue(6'b000000, 3'd3, 3'd1, 3'd2, 4'd9, 64'd0, 0, 1, 1, 0, 0, 0, a);
        // in-place XOR over full length, with instr_valid held while busy
        issue(6'b000110, 3'd7, 3'd7, 3'd7, 4'd8, 64'd0, 8, 1, 0, 1, 0, 3, a);

        // reset lands in cycle 4 of an 8-element ADD: only elements 0 and 1 get written
        issue(6'b000000, 3'd2, 3'd7, 3'd1, 4'd8, {48'd0, 8'd2, 8'd1}, 2, 0, 0, 0, 0, 0, a);
        while (ecnt < a + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", int'(rf_we), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(instr_ready), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(6'b000000, 3'd6, 3'd1, 3'd2, 4'd4, {32'd0, 8'd44, 8'd33, 8'd4, 8'd2},
              4, 1, 0, 0, 0, 0, a);

        repeat (4) @(negedge clk);
        chk("writes_pending", wq.size(), 0);
        chk("dones_pending", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
